// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian data memory with a req/ready handshake and a fixed
// access latency; sits beside the core in place of the zero-latency data memory.
module data_mem_responder #(
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             mem_req,
  input  logic [31:0]      mem_addr,
  input  logic             mem_write_en,
  input  logic [0:3][7:0]  mem_data_in,
  output logic [0:3][7:0]  mem_data_out,
  output logic             mem_ready,
  output logic             busy
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [0:3][7:0]  wdata_q, wdata_d;
  logic [0:3][7:0]  rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             complete;

  logic [7:0]       storage_q [0:MEM_BYTES-1];
  logic [AW-1:0]    lane_idx  [0:3];

  // Only the low address bits index storage; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:AW];

  // Index arithmetic is AW bits wide, so lanes wrap at MEM_BYTES for free.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_idx[gi] = addr_q + AW'(gi);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr[AW-1:0];
          we_d    = mem_write_en;
          wdata_d = mem_data_in;
          count_d = CW'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q > CW'(1)) begin
          count_d = count_q - CW'(1);
        end else begin
          complete = 1'b1;
          ready_d  = 1'b1;
          count_d  = '0;
          state_d  = IDLE;
          if (!we_q) begin
            for (int i = 0; i < 4; i++) begin
              rdata_d[i] = storage_q[lane_idx[i]];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Write commits on the completion edge, so a following read sees it.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        storage_q[i] <= 8'h00;
      end
    end else if (complete && we_q) begin
      for (int i = 0; i < 4; i++) begin
        storage_q[lane_idx[i]] <= wdata_q[i];
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;
  assign busy         = (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder, checked every cycle
// against a timestamp-based behavioural model of the memory.
module tb_data_mem_responder;

  localparam int LAT = 2;
  localparam int MB  = 4096;

  logic             clk = 1'b0;
  logic             rst_b = 1'b1;
  logic             mem_req = 1'b0;
  logic [31:0]      mem_addr = '0;
  logic             mem_write_en = 1'b0;
  logic [0:3][7:0]  mem_data_in = '0;
  logic [0:3][7:0]  mem_data_out;
  logic             mem_ready;
  logic             busy;

  data_mem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: an access accepted at edge N finishes at edge N+LAT.
  logic [7:0]  mm [0:MB-1];
  int          edge_no = 0;
  int          done_edge = 0;
  bit          inflight = 0;
  bit          exp_ready = 0;
  logic [31:0] exp_data = '0;
  logic [31:0] m_addr, m_wdata;
  bit          m_we;

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < MB; i++) mm[i] = 8'h00;
      inflight  = 0;
      exp_ready = 0;
      exp_data  = '0;
    end else begin
      edge_no++;
      exp_ready = 0;
      if (inflight) begin
        if (edge_no == done_edge) begin
          for (int i = 0; i < 4; i++) begin
            int idx;
            idx = ((m_addr % MB) + i) % MB;
            if (m_we) mm[idx] = m_wdata[31-8*i -: 8];
            else exp_data[31-8*i -: 8] = mm[idx];
          end
          exp_ready = 1;
          inflight  = 0;
        end
      end else if (mem_req) begin
        m_addr    = mem_addr;
        m_we      = mem_write_en;
        m_wdata   = mem_data_in;
        inflight  = 1;
        done_edge = edge_no + LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst_b) begin
      chk("ready", 32'(mem_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(inflight));
      chk("rdata", mem_data_out, exp_data);
    end
  end

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input bit junk);
    int lat;
    @(posedge clk); #1;
    mem_req = 1; mem_addr = a; mem_write_en = w; mem_data_in = d;
    @(posedge clk); #1;
    mem_req = 0;
    lat = 0;
    while (!mem_ready && lat < 50) begin
      if (junk) begin
        mem_req = 1'($urandom_range(0, 1));
        mem_addr = 32'h40;
        mem_write_en = 1;
        mem_data_in = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    mem_req = 0;
    mem_write_en = 0;
    chk("ready_seen", 32'(mem_ready), 32'd1);
    chk("latency", lat, LAT);
    $display("txn %s addr=%h wdata=%h rdata=%h lat=%0d", w ? "WR" : "RD", a, d,
             mem_data_out, lat);
  endtask

  task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    access(a, 1'b0, 32'h0, 1'b0);
    chk(name, mem_data_out, exp);
  endtask

  initial begin
    int pulses, cyc, last, first;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 rst_b = 0;
    chk_en = 1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(mem_ready), 32'd0);
    chk("reset_data", mem_data_out, 32'h0);

    // Reset then read
    rd_expect("rd_0x10", 32'h10, 32'h00000000);

    // Write then read, including unaligned
    access(32'h20, 1'b1, 32'hDEADBEEF, 1'b0);
    rd_expect("rd_0x20", 32'h20, 32'hDEADBEEF);
    rd_expect("rd_0x21", 32'h21, 32'hADBEEF00);

    // Wrap and alias
    access(32'hFFE, 1'b1, 32'h11223344, 1'b0);
    rd_expect("rd_wrap0", 32'h0, 32'h33440000);
    rd_expect("rd_alias", 32'h1FFE, 32'h11223344);

    // Inputs wiggled while busy are ignored
    access(32'h20, 1'b0, 32'h0, 1'b1);
    chk("busy_ignore_data", mem_data_out, 32'hDEADBEEF);
    rd_expect("rd_0x40", 32'h40, 32'h00000000);

    // Back-to-back reads with mem_req held high
    @(posedge clk); #1;
    mem_req = 1; mem_write_en = 0; mem_addr = 32'h20;
    pulses = 0; cyc = 0; last = 0; first = 0;
    while (pulses < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) begin
        if (pulses == 0) first = cyc;
        else chk("b2b_gap", cyc - last, LAT + 1);
        last = cyc;
        pulses++;
        $display("txn RD b2b addr=%h rdata=%h cyc=%0d", mem_addr, mem_data_out, cyc);
      end
    end
    mem_req = 0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_first", first, LAT + 1);

    // Reset one edge into a write aborts it
    @(posedge clk); #1;
    mem_req = 1; mem_write_en = 1; mem_addr = 32'h8; mem_data_in = 32'hAABBCCDD;
    @(posedge clk); #1;
    mem_req = 0; mem_write_en = 0;
    @(posedge clk); #1;
    rst_b = 1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_ready", 32'(mem_ready), 32'd0);
    end
    rst_b = 0;
    $display("txn RST mid-write addr=00000008");
    rd_expect("rd_0x8", 32'h8, 32'h00000000);

    // Randomized traffic concentrated on a few regions so reads hit writes
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'hFFC + $urandom_range(0, 3);
        2: a = $urandom_range(0, 15);
        default: a = ($urandom_range(0, 7) << 12) | $urandom_range(0, 31);
      endcase
      access(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface. It accepts the core's address, four-byte write data and write enable, and returns four-byte read data.
- It is a byte-addressed, big-endian memory: byte lane [0] is the most significant byte.
- It adds a req/ready handshake with configurable access latency, so the core can be moved to a multi-cycle memory model.
- It sits beside the processor core in the machine top level, in place of the zero-latency data memory.

Parameters:
- MEM_BYTES, 4096, storage size in bytes; power of two, at least 4.
- LATENCY, 2, clock edges from request acceptance to completion; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  reset, asynchronous, active-high (despite the _b suffix, which matches the codebase port name).
- mem_req  in  1  request strobe from the core.
- mem_addr  in  32  byte address of the access.
- mem_write_en  in  1  1 = write, 0 = read; sampled with mem_req.
- mem_data_in  in  4x8 (array [0:3])  write data; lane [0] is the MSB.
- mem_data_out  out  4x8 (array [0:3])  read data; lane [0] is the MSB.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight.

Behaviour:
- Reset (asserted asynchronously, held while rst_b=1):
  - state=IDLE, counter=0, mem_ready=0, busy=0.
  - All four mem_data_out lanes = 8'h00.
  - All storage bytes cleared to 0.
  - Latched request registers cleared.
  - Reset asserted mid-access aborts the access: no write is committed and no mem_ready pulse is produced.
- FSM has two states, IDLE and BUSY.
- IDLE, on a rising edge with mem_req=1:
  - Latch mem_addr, mem_write_en and mem_data_in.
  - Load counter=LATENCY, go to BUSY, busy=1.
  - mem_req=0 in IDLE: no action.
- BUSY, each rising edge:
  - If counter>1: decrement.
  - If counter==1, complete the access and on the same edge return to IDLE with busy=0 and mem_ready=1.
  - Write completion: storage[(A+i) mod MEM_BYTES] <= lane[i] for i=0..3.
  - Read completion: mem_data_out lane[i] <= storage[(A+i) mod MEM_BYTES].
- mem_ready is registered and lasts exactly one cycle. It falls on the next edge unless that edge completes another access, which is impossible because the minimum access is LATENCY+1 edges.
- Timing: a request accepted at edge N completes at edge N+LATENCY. mem_ready is high between edges N+LATENCY and N+LATENCY+1.
- Back-to-back: mem_req high during the mem_ready cycle (state is IDLE) is accepted at that edge. Maximum throughput is one access per LATENCY+1 cycles... correction: accepted at edge N+LATENCY+1, giving one access every LATENCY+1 edges.
- mem_req asserted while BUSY is ignored and not queued. The core must hold mem_req until it sees mem_ready and then re-present the request.
- mem_data_out holds the last read result until the next read completes. Write completions leave mem_data_out unchanged.
- Address rules:
  - Storage is indexed by mem_addr mod MEM_BYTES; upper address bits are ignored.
  - Unaligned addresses are legal and access four consecutive bytes.
  - Byte indices wrap at MEM_BYTES: with MEM_BYTES=4096 and address 4094, bytes 4094, 4095, 0 and 1 are accessed.
- Input changes on mem_addr, mem_data_in or mem_write_en during BUSY have no effect, because the latched copies are used.
- Read-after-write to the same address in consecutive accesses returns the newly written data; there is no bypass hazard because the write commits before the next acceptance.

Test Plan:
1. Reset then read: rst_b pulse; read address 0x10 with LATENCY=2 -> mem_ready high exactly 2 edges after acceptance; mem_data_out = {00,00,00,00}; busy high for 2 cycles.
2. Write then read: write 0x20 with lanes {DE,AD,BE,EF}, then read 0x20 -> mem_data_out = {DE,AD,BE,EF}; read 0x21 -> {AD,BE,EF,00}.
3. Wrap and alias: write 0xFFE (MEM_BYTES=4096) with {11,22,33,44} -> read 0x0 returns {33,44,00,00}; read 0x1FFE returns {11,22,33,44}.
4. Busy ignore: request read 0x20, then toggle mem_req and set mem_addr=0x40 and mem_write_en=1 during BUSY -> single mem_ready; data comes from 0x20; no write at 0x40 (a later read of 0x40 returns 0s).
5. Back-to-back: mem_req held high for 3 reads with LATENCY=1 -> mem_ready pulses every 2 cycles, 3 pulses total.
6. Reset mid-write: start write {AA,BB,CC,DD} to 0x8, assert rst_b one edge later -> mem_ready never pulses, busy=0 immediately, a subsequent read of 0x8 returns 0s.
